// File: rtl/kernel_host_pkg.sv
// kernel_host shared defaults, state encoding and checksum width.
package kernel_host_pkg;

  localparam int DEPTH_D  = 1000;
  localparam int ADDR_W_D = 10;
  localparam int DATA_W_D = 27;
  localparam int CK_W     = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    VERIFY,
    START,
    WAIT,
    OUT,
    ERR
  } state_t;

endpackage

// File: rtl/kernel_host_cksum.sv
// kernel_host checksum: sign-extended 32-bit wrap-around accumulator.
module kernel_host_cksum
  import kernel_host_pkg::*;
#(
  parameter int DATA_W = DATA_W_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [CK_W-1:0]   sum,
  output logic [CK_W-1:0]   nxt
);

  logic [CK_W-1:0] ext;

  assign ext = CK_W'(signed'(din));
  assign nxt = sum + ext;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sum <= '0;
    end else if (en) begin
      sum <= nxt;
    end
  end

endmodule

// File: rtl/kernel_host.sv
// kernel_host: loads DEPTH words into a kernel array, runs it, returns result.
// Optional readback check enabled by KERNEL_HOST_READBACK_EN.
module kernel_host
  import kernel_host_pkg::*;
#(
  parameter int DEPTH  = DEPTH_D,
  parameter int ADDR_W = ADDR_W_D,
  parameter int DATA_W = DATA_W_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [63:0]       cfg_i,
  input  logic [63:0]       cfg_acc,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [63:0]       res_data,
  output logic              err,
  output logic              busy,
  output logic [31:0]       cycles,
  output logic              k_r_enable,
  output logic [63:0]       k_init_i,
  output logic [63:0]       k_init_acc,
  output logic              k_controlArr,
  output logic              k_arrWEnable,
  output logic [ADDR_W-1:0] k_arrAddr,
  output logic [DATA_W-1:0] k_arrWData,
  input  logic [DATA_W-1:0] k_arrRData,
  input  logic              k_w_enable,
  input  logic [63:0]       k_result
);

`ifdef KERNEL_HOST_READBACK_EN
  localparam state_t LOAD_NX = VERIFY;
`else
  localparam state_t LOAD_NX = START;
`endif

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] cnt;
  logic [63:0]       i_q;
  logic [63:0]       acc_q;
  logic              take;
  logic              last;
  logic              ck_ok;

  assign take       = start && (state == IDLE || state == ERR);
  assign last       = (cnt == ADDR_W'(DEPTH - 1));
  assign busy       = (state != IDLE);
  assign k_init_i   = i_q;
  assign k_init_acc = acc_q;

`ifdef KERNEL_HOST_READBACK_EN
  logic [CK_W-1:0] wr_sum;
  logic [CK_W-1:0] wr_nxt_unused;
  logic [CK_W-1:0] rd_sum_unused;
  logic [CK_W-1:0] rd_nxt;
  logic            err_q;

  kernel_host_cksum #(.DATA_W(DATA_W)) u_wr_ck (
    .clk (clk),
    .rst (rst),
    .clr (take),
    .en  (state == LOAD && s_valid),
    .din (s_data),
    .sum (wr_sum),
    .nxt (wr_nxt_unused)
  );

  kernel_host_cksum #(.DATA_W(DATA_W)) u_rd_ck (
    .clk (clk),
    .rst (rst),
    .clr (take),
    .en  (state == VERIFY),
    .din (k_arrRData),
    .sum (rd_sum_unused),
    .nxt (rd_nxt)
  );

  // the last read word is folded in before comparing
  assign ck_ok = (rd_nxt == wr_sum);
  assign err   = err_q;

  always_ff @(posedge clk) begin
    if (rst || take) begin
      err_q <= 1'b0;
    end else if (state == VERIFY && last && !ck_ok) begin
      err_q <= 1'b1;
    end
  end
`else
  logic rdata_unused;

  assign rdata_unused = ^k_arrRData;
  assign ck_ok        = 1'b1;
  assign err          = 1'b0;
`endif

  always_comb begin
    state_nx     = state;
    s_ready      = 1'b0;
    k_controlArr = 1'b0;
    k_arrWEnable = 1'b0;
    k_arrAddr    = '0;
    k_arrWData   = '0;
    k_r_enable   = 1'b0;
    res_valid    = 1'b0;
    unique case (state)
      IDLE, ERR: begin
        if (start) state_nx = LOAD;
      end
      LOAD: begin
        s_ready      = 1'b1;
        k_controlArr = 1'b1;
        k_arrAddr    = cnt;
        k_arrWData   = s_data;
        k_arrWEnable = s_valid;
        if (s_valid && last) state_nx = LOAD_NX;
      end
      VERIFY: begin
        k_controlArr = 1'b1;
        k_arrAddr    = cnt;
        if (last) state_nx = ck_ok ? START : ERR;
      end
      START: begin
        k_r_enable = 1'b1;
        state_nx   = WAIT;
      end
      WAIT: begin
        if (k_w_enable) state_nx = OUT;
      end
      OUT: begin
        res_valid = 1'b1;
        if (res_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      i_q      <= '0;
      acc_q    <= '0;
      cycles   <= '0;
      res_data <= '0;
    end else begin
      state <= state_nx;
      if (take) begin
        i_q    <= cfg_i;
        acc_q  <= cfg_acc;
        cnt    <= '0;
        cycles <= '0;
      end
      if ((state == LOAD && s_valid) || state == VERIFY) begin
        cnt <= last ? '0 : cnt + ADDR_W'(1);
      end
      if (state == WAIT) begin
        if (cycles != '1) cycles <= cycles + 32'd1;
        if (k_w_enable) res_data <= k_result;
      end
    end
  end

endmodule

// File: tb/tb_kernel_host.sv
// kernel_host bench: array/kernel model plus job-level scoreboard.
module tb_kernel_host;

  localparam int DEPTH  = 1000;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 27;
  localparam int LAT    = 50;
  localparam logic [63:0] RES = 64'h1234;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [63:0]       cfg_i = '0;
  logic [63:0]       cfg_acc = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_data = '0;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [63:0]       res_data;
  logic              err;
  logic              busy;
  logic [31:0]       cycles;
  logic              k_r_enable;
  logic [63:0]       k_init_i;
  logic [63:0]       k_init_acc;
  logic              k_controlArr;
  logic              k_arrWEnable;
  logic [ADDR_W-1:0] k_arrAddr;
  logic [DATA_W-1:0] k_arrWData;
  logic [DATA_W-1:0] k_arrRData;
  logic              k_w_enable;
  logic [63:0]       k_result;

  kernel_host #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cfg_i       (cfg_i),
    .cfg_acc     (cfg_acc),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .err         (err),
    .busy        (busy),
    .cycles      (cycles),
    .k_r_enable  (k_r_enable),
    .k_init_i    (k_init_i),
    .k_init_acc  (k_init_acc),
    .k_controlArr(k_controlArr),
    .k_arrWEnable(k_arrWEnable),
    .k_arrAddr   (k_arrAddr),
    .k_arrWData  (k_arrWData),
    .k_arrRData  (k_arrRData),
    .k_w_enable  (k_w_enable),
    .k_result    (k_result)
  );

  always #5 clk = ~clk;

  int passes = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // kernel model: array memory, optional corruption of word 7, fixed latency
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  bit                corrupt = 1'b0;
  logic              k_done;
  int                kc;
  bit                k_run;

  assign k_arrRData = mem[k_arrAddr];
  assign k_w_enable = k_done;
  assign k_result   = k_done ? RES : 64'hdead_beef;

  always @(posedge clk) begin
    if (k_controlArr && k_arrWEnable)
      mem[k_arrAddr] <= (corrupt && k_arrAddr == 7) ? (k_arrWData ^ 1) : k_arrWData;
  end

  always @(posedge clk) begin
    if (rst) begin
      k_done <= 1'b0;
      k_run  <= 1'b0;
      kc     <= 0;
    end else if (k_r_enable) begin
      k_done <= 1'b0;
      k_run  <= 1'b1;
      kc     <= 1;
    end else if (k_run) begin
      if (kc == LAT - 1) begin
        k_done <= 1'b1;
        k_run  <= 1'b0;
      end else begin
        kc <= kc + 1;
      end
    end
  end

  // scoreboard state
  logic [63:0] m_i = '0;
  logic [63:0] m_acc = '0;
  int          m_idx = 0;
  bit          pend = 1'b0;
  int          wr_cnt = 0;
  int          pulses = 0;
  int          first_addr = -1;

  always @(negedge clk) begin
    if (!rst) begin
      chk("init_i", k_init_i, m_i);
      chk("init_acc", k_init_acc, m_acc);
      chk("wen_hs", 64'(k_arrWEnable), 64'(s_valid && s_ready));
      if (!busy) chk("idle_s_ready", 64'(s_ready), 64'd0);
      if (k_arrWEnable) begin
        chk("waddr", 64'(k_arrAddr), 64'(m_idx));
        chk("wdata", 64'(k_arrWData), 64'(m_idx));
        if (wr_cnt == 0) first_addr = int'(k_arrAddr);
        wr_cnt++;
      end
      if (k_r_enable) begin
        chk("start_ctl", 64'(k_controlArr), 64'd0);
        pulses++;
      end
    end
    if (rst) begin
      m_i   = '0;
      m_acc = '0;
      m_idx = 0;
    end else if (start && pend) begin
      m_i   = cfg_i;
      m_acc = cfg_acc;
      m_idx = 0;
      pend  = 1'b0;
    end else if (s_valid && s_ready) begin
      m_idx++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [63:0] ci, input logic [63:0] ca);
    wr_cnt     = 0;
    pulses     = 0;
    first_addr = -1;
    cfg_i      = ci;
    cfg_acc    = ca;
    start      = 1'b1;
    pend       = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load(input int n_words, input bit toggle);
    int n = 0;
    int cyc = 0;
    bit hs;
    while (n < n_words && cyc < 5000) begin
      s_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      s_data  = DATA_W'(n);
      @(negedge clk);
      hs = s_valid && s_ready;
      tick();
      if (hs) n++;
      cyc++;
    end
    s_valid = 1'b0;
    chk("load_words", 64'(n), 64'(n_words));
  endtask

  task automatic wait_res(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (res_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic finish_job(input bit hold);
    bit ok;
    wait_res(ok);
    chk("res_seen", 64'(ok), 64'd1);
    chk("res_data", res_data, RES);
    chk("cycles", 64'(cycles), 64'd50);
    chk("writes", 64'(wr_cnt), 64'd1000);
    chk("first_addr", 64'(first_addr), 64'd0);
    chk("pulses", 64'(pulses), 64'd1);
    chk("err_clear", 64'(err), 64'd0);
    if (hold) begin
      for (int h = 0; h < 5; h++) begin
        tick();
        @(negedge clk);
        chk("hold_valid", 64'(res_valid), 64'd1);
        chk("hold_data", res_data, RES);
      end
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    @(negedge clk);
    chk("back_idle", 64'(busy), 64'd0);
    chk("res_drop", 64'(res_valid), 64'd0);
    tick();
  endtask

  initial begin
    bit ok;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_ctl", 64'(k_controlArr), 64'd0);
    chk("rst_renable", 64'(k_r_enable), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data", res_data, 64'd0);
    chk("rst_cycles", 64'(cycles), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    tick();

    // full job, continuous samples
    do_start(64'h0000_0001_0000_0002, 64'h00ab_cdef_0123_4567);
    load(DEPTH, 1'b0);
    finish_job(1'b0);

    // backpressure: s_valid toggles every cycle
    do_start(64'h11, 64'h22);
    load(DEPTH, 1'b1);
    finish_job(1'b0);

    // result hold under res_ready=0
    do_start(64'h33, 64'h44);
    load(DEPTH, 1'b0);
    finish_job(1'b1);

    // mid-load reset at sample 500
    do_start(64'h55, 64'h66);
    load(500, 1'b0);
    s_valid = 1'b1;
    s_data  = DATA_W'(500);
    rst     = 1'b1;
    tick();
    rst     = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    chk("mrst_s_ready", 64'(s_ready), 64'd0);
    chk("mrst_ctl", 64'(k_controlArr), 64'd0);
    chk("mrst_renable", 64'(k_r_enable), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_init_i", k_init_i, 64'd0);
    tick();
    do_start(64'h77, 64'h88);
    load(DEPTH, 1'b0);
    finish_job(1'b0);

    // start while in WAIT must be ignored
    do_start(64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210);
    load(DEPTH, 1'b0);
    for (int c = 0; c < 100 && pulses == 0; c++) @(negedge clk);
    tick();
    tick();
    cfg_i   = 64'hdead;
    cfg_acc = 64'hbeef;
    start   = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("wait_cfg_i", k_init_i, 64'h0123_4567_89ab_cdef);
    chk("wait_busy", 64'(busy), 64'd1);
    finish_job(1'b0);

    // readback: word 7 corrupted inside the kernel array
    corrupt = 1'b1;
    do_start(64'h99, 64'haa);
    load(DEPTH, 1'b0);
`ifdef KERNEL_HOST_READBACK_EN
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (err) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rb_err", 64'(ok), 64'd1);
    repeat (60) tick();
    @(negedge clk);
    chk("rb_err_sticky", 64'(err), 64'd1);
    chk("rb_busy", 64'(busy), 64'd1);
    chk("rb_no_pulse", 64'(pulses), 64'd0);
    chk("rb_no_res", 64'(res_valid), 64'd0);
    tick();
`else
    ok = 1'b1;
    finish_job(1'b0);
`endif
    corrupt = 1'b0;
    do_start(64'hbb, 64'hcc);
    @(negedge clk);
    chk("restart_err", 64'(err), 64'd0);
    tick();
    load(DEPTH, 1'b0);
    finish_job(1'b0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
